mem_stage_sram_controller: RTL and testbench

// Sequences the MEM-stage data access to an external multi-cycle SRAM.

---
 rtl/mem_stage_sram_controller_if.sv | 62 ++++++
 rtl/mem_stage_sram_controller.sv | 95 +++++++++
 tb/tb_mem_stage_sram_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_sram_controller_if.sv
// Bundle of the MEM-stage pipeline request and the external SRAM bus.
//
// Handshake: memoryReadEnabled/memoryWriteEnabled act as the request valid
// from the EXE->MEM stage register. A request is taken only while the
// controller is IDLE. ready is the pipeline-advance signal: 1 lets every
// stage register load, 0 freezes them all. The requester keeps its request
// stable while ready is 0.
//
// Signals:
//   memoryReadEnabled   load request
//   memoryWriteEnabled  store request (wins over a load when both are high)
//   aluResult           byte address of the access
//   data                store data
//   sram_rdata          SRAM read data
//   sram_addr           SRAM word address (18 bits)
//   sram_wdata          SRAM write data
//   sram_en             SRAM access active
//   sram_we_n           SRAM write enable, active-low
//   readData            captured load data for the MEM->WB stage register
//   ready               1 = pipeline may advance
// Modports: slave = controller side, master = pipeline/SRAM side.
interface mem_stage_sram_controller_if;
  logic        memoryReadEnabled;
  logic        memoryWriteEnabled;
  logic [31:0] aluResult;
  logic [31:0] data;
  logic [31:0] sram_rdata;
  logic [17:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_en;
  logic        sram_we_n;
  logic [31:0] readData;
  logic        ready;

  modport slave (
    input  memoryReadEnabled,
    input  memoryWriteEnabled,
    input  aluResult,
    input  data,
    input  sram_rdata,
    output sram_addr,
    output sram_wdata,
    output sram_en,
    output sram_we_n,
    output readData,
    output ready
  );

  modport master (
    output memoryReadEnabled,
    output memoryWriteEnabled,
    output aluResult,
    output data,
    output sram_rdata,
    input  sram_addr,
    input  sram_wdata,
    input  sram_en,
    input  sram_we_n,
    input  readData,
    input  ready
  );
endinterface

// File: rtl/mem_stage_sram_controller.sv
// MEM-stage controller for an external multi-cycle SRAM.
// Latches address/store data when a request arrives in IDLE, holds the SRAM
// enabled for WAIT_CYCLES cycles, captures read data on the final access
// edge and then gives the pipeline exactly one ready cycle (DONE).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   bus        mem_stage_sram_controller_if.slave (request, SRAM bus, ready)
//   state_dbg  current FSM state (0 = IDLE, 1 = ACCESS, 2 = DONE)
// Parameters:
//   WAIT_CYCLES  SRAM access length in cycles, 1..15
//   ADDR_BASE    byte address mapped to SRAM word 0
module mem_stage_sram_controller #(
  parameter int WAIT_CYCLES = 5,
  parameter int ADDR_BASE   = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  mem_stage_sram_controller_if.slave    bus,
  output logic [1:0]                    state_dbg
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          req;
  logic [31:0]   offset;

  assign req = bus.memoryReadEnabled | bus.memoryWriteEnabled;

  // Unsigned 32-bit subtract; addresses below the base wrap before the shift.
  assign offset = bus.aluResult - 32'(ADDR_BASE);

  // ready drops in the same cycle a request is seen so no stage register
  // advances past the access being started.
  assign bus.ready = (state == DONE) || ((state == IDLE) && !req);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.sram_en    <= 1'b0;
      bus.sram_we_n  <= 1'b1;
      bus.sram_addr  <= '0;
      bus.sram_wdata <= '0;
      bus.readData   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            bus.sram_addr  <= 18'(offset >> 2);
            bus.sram_wdata <= bus.data;
            bus.sram_en    <= 1'b1;
            // Write wins when both requests are high.
            bus.sram_we_n  <= ~bus.memoryWriteEnabled;
            cnt            <= '0;
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            // sram_we_n still high here means this access is a read.
            if (bus.sram_we_n) begin
              bus.readData <= bus.sram_rdata;
            end
            bus.sram_en   <= 1'b0;
            bus.sram_we_n <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          // A request still present here is taken in the following IDLE cycle.
          state <= IDLE;
        end
        default: begin
          bus.sram_en   <= 1'b0;
          bus.sram_we_n <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_controller.sv
// Directed bench for mem_stage_sram_controller. A WAIT_CYCLES=5 instance is
// driven from a per-cycle vector table; a WAIT_CYCLES=1 instance gets a few
// hand-written latency sequences.
module tb_mem_stage_sram_controller;

  localparam logic [1:0] S_I = 2'd0;
  localparam logic [1:0] S_A = 2'd1;
  localparam logic [1:0] S_D = 2'd2;

  logic       clk;
  logic       rst5, rst1;
  logic [1:0] st5, st1;
  int         n_vec;
  int         n_err;

  mem_stage_sram_controller_if if5 ();
  mem_stage_sram_controller_if if1 ();

  mem_stage_sram_controller #(.WAIT_CYCLES(5), .ADDR_BASE(1024)) dut5 (
    .clk(clk), .rst(rst5), .bus(if5), .state_dbg(st5)
  );

  mem_stage_sram_controller #(.WAIT_CYCLES(1), .ADDR_BASE(1024)) dut1 (
    .clk(clk), .rst(rst1), .bus(if1), .state_dbg(st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [1:0]  e_state;
    logic        e_ready;
    logic        e_en;
    logic        e_we_n;
    logic [17:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic rd_i, input logic wr_i,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                     input logic [1:0] st, input logic er, input logic ee, input logic ew,
                     input logic [17:0] ea, input logic [31:0] ewd, input logic [31:0] erd);
    vec_t v;
    v.rst = r; v.rd = rd_i; v.wr = wr_i; v.addr = a; v.data = d; v.rdata = rdat;
    v.e_state = st; v.e_ready = er; v.e_en = ee; v.e_we_n = ew;
    v.e_addr = ea; v.e_wdata = ewd; v.e_rdata = erd;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then check mid-cycle.
  task automatic apply_row(input int idx, input vec_t v);
    @(negedge clk);
    rst5 = v.rst;
    if5.memoryReadEnabled  = v.rd;
    if5.memoryWriteEnabled = v.wr;
    if5.aluResult          = v.addr;
    if5.data               = v.data;
    if5.sram_rdata         = v.rdata;
    #1;
    chk($sformatf("row%0d state", idx), 32'(st5), 32'(v.e_state));
    chk($sformatf("row%0d ready", idx), 32'(if5.ready), 32'(v.e_ready));
    chk($sformatf("row%0d sram_en", idx), 32'(if5.sram_en), 32'(v.e_en));
    chk($sformatf("row%0d sram_we_n", idx), 32'(if5.sram_we_n), 32'(v.e_we_n));
    chk($sformatf("row%0d sram_addr", idx), 32'(if5.sram_addr), 32'(v.e_addr));
    chk($sformatf("row%0d sram_wdata", idx), if5.sram_wdata, v.e_wdata);
    chk($sformatf("row%0d readData", idx), if5.readData, v.e_rdata);
  endtask

  // Issue one request on the WAIT_CYCLES=1 instance and count, until ready
  // returns, the cycles with ready low, sram_en high and sram_we_n low.
  task automatic measure1(input logic rd_i, input logic wr_i, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rdat,
                          output int low, output int en_n, output int we_n, output int guard);
    low = 0; en_n = 0; we_n = 0; guard = 0;
    @(negedge clk);
    if1.memoryReadEnabled  = rd_i;
    if1.memoryWriteEnabled = wr_i;
    if1.aluResult          = a;
    if1.data               = d;
    if1.sram_rdata         = rdat;
    #1;
    while (if1.ready == 1'b0 && guard < 20) begin
      low++;
      if (if1.sram_en) en_n++;
      if (!if1.sram_we_n) we_n++;
      @(negedge clk);
      if1.memoryReadEnabled  = 1'b0;
      if1.memoryWriteEnabled = 1'b0;
      #1;
      guard++;
    end
  endtask

  initial begin
    int low, en_n, we_n, guard;
    n_vec = 0;
    n_err = 0;
    rst5 = 1'b0;
    rst1 = 1'b0;
    if5.memoryReadEnabled = 1'b0; if5.memoryWriteEnabled = 1'b0;
    if5.aluResult = '0; if5.data = '0; if5.sram_rdata = '0;
    if1.memoryReadEnabled = 1'b0; if1.memoryWriteEnabled = 1'b0;
    if1.aluResult = '0; if1.data = '0; if1.sram_rdata = '0;
    repeat (2) @(posedge clk);

    //   n  rst rd wr addr           data           rdata          st  rdy en wen addr        wdata          readData
    // reset state, idle
    add(1, 1, 0, 0, 32'd0,        32'd0,         32'd0,         S_I, 1, 0, 1, 18'd0,       32'd0,         32'd0);
    // read 1028 -> word 1
    add(1, 1, 1, 0, 32'd1028,     32'h11111111,  32'd0,         S_I, 0, 0, 1, 18'd0,       32'd0,         32'd0);
    add(5, 1, 0, 0, 32'd0,        32'd0,         32'hDEADBEEF,  S_A, 0, 1, 1, 18'd1,       32'h11111111,  32'd0);
    add(1, 1, 0, 0, 32'd0,        32'd0,         32'd0,         S_D, 1, 0, 1, 18'd1,       32'h11111111,  32'hDEADBEEF);
    add(1, 1, 0, 0, 32'd0,        32'd0,         32'd0,         S_I, 1, 0, 1, 18'd1,       32'h11111111,  32'hDEADBEEF);
    // write 1032 -> word 2, inputs changed during ACCESS are ignored
    add(1, 1, 0, 1, 32'd1032,     32'h12345678,  32'd0,         S_I, 0, 0, 1, 18'd1,       32'h11111111,  32'hDEADBEEF);
    add(5, 1, 0, 0, 32'd0,        32'hFFFFFFFF,  32'h55555555,  S_A, 0, 1, 0, 18'd2,       32'h12345678,  32'hDEADBEEF);
    add(1, 1, 0, 0, 32'd0,        32'd0,         32'd0,         S_D, 1, 0, 1, 18'd2,       32'h12345678,  32'hDEADBEEF);
    // read+write together at 1024 -> write to word 0, readData untouched
    add(1, 1, 1, 1, 32'd1024,     32'hCAFEF00D,  32'h0BADF00D,  S_I, 0, 0, 1, 18'd2,       32'h12345678,  32'hDEADBEEF);
    add(5, 1, 1, 1, 32'd1024,     32'hCAFEF00D,  32'h0BADF00D,  S_A, 0, 1, 0, 18'd0,       32'hCAFEF00D,  32'hDEADBEEF);
    add(1, 1, 1, 1, 32'd1024,     32'hCAFEF00D,  32'h0BADF00D,  S_D, 1, 0, 1, 18'd0,       32'hCAFEF00D,  32'hDEADBEEF);
    // back-to-back reads: 1036 (word 3) then 1040 (word 4)
    add(1, 1, 1, 0, 32'd1036,     32'd0,         32'h01020304,  S_I, 0, 0, 1, 18'd0,       32'hCAFEF00D,  32'hDEADBEEF);
    add(5, 1, 1, 0, 32'd1036,     32'd0,         32'h01020304,  S_A, 0, 1, 1, 18'd3,       32'd0,         32'hDEADBEEF);
    add(1, 1, 1, 0, 32'd1040,     32'd0,         32'h05060708,  S_D, 1, 0, 1, 18'd3,       32'd0,         32'h01020304);
    add(1, 1, 1, 0, 32'd1040,     32'd0,         32'h05060708,  S_I, 0, 0, 1, 18'd3,       32'd0,         32'h01020304);
    add(5, 1, 1, 0, 32'd1040,     32'd0,         32'h05060708,  S_A, 0, 1, 1, 18'd4,       32'd0,         32'h01020304);
    add(1, 1, 0, 0, 32'd0,        32'd0,         32'd0,         S_D, 1, 0, 1, 18'd4,       32'd0,         32'h05060708);
    // address below base wraps; low two bits ignored: (0x13-0x400)>>2 -> 0x3FF04
    add(1, 1, 1, 0, 32'h00000013, 32'h00000009,  32'h00000077,  S_I, 0, 0, 1, 18'd4,       32'd0,         32'h05060708);
    add(5, 1, 0, 0, 32'd0,        32'd0,         32'h00000077,  S_A, 0, 1, 1, 18'h3FF04,   32'h00000009,  32'h05060708);
    add(1, 1, 0, 0, 32'd0,        32'd0,         32'd0,         S_D, 1, 0, 1, 18'h3FF04,   32'h00000009,  32'h00000077);
    // reset during the 3rd ACCESS cycle aborts the read
    add(1, 1, 1, 0, 32'd1028,     32'd0,         32'h0000ABCD,  S_I, 0, 0, 1, 18'h3FF04,   32'h00000009,  32'h00000077);
    add(2, 1, 0, 0, 32'd0,        32'd0,         32'h0000ABCD,  S_A, 0, 1, 1, 18'd1,       32'd0,         32'h00000077);
    add(1, 0, 0, 0, 32'd0,        32'd0,         32'h0000ABCD,  S_A, 0, 1, 1, 18'd1,       32'd0,         32'h00000077);
    add(2, 1, 0, 0, 32'd0,        32'd0,         32'd0,         S_I, 1, 0, 1, 18'd0,       32'd0,         32'd0);

    foreach (vecs[i]) apply_row(i, vecs[i]);

    // WAIT_CYCLES=1 instance
    @(negedge clk);
    rst1 = 1'b1;
    #1;
    chk("w1 idle ready", 32'(if1.ready), 32'd1);
    chk("w1 idle readData", if1.readData, 32'd0);

    measure1(1'b1, 1'b0, 32'd1028, 32'd0, 32'h600DCAFE, low, en_n, we_n, guard);
    chk("w1 read timeout", 32'(guard < 20), 32'd1);
    chk("w1 read ready_low_cycles", 32'(low), 32'd2);
    chk("w1 read en_cycles", 32'(en_n), 32'd1);
    chk("w1 read we_low_cycles", 32'(we_n), 32'd0);
    chk("w1 read state_done", 32'(st1), 32'(S_D));
    chk("w1 read readData", if1.readData, 32'h600DCAFE);
    chk("w1 read sram_addr", 32'(if1.sram_addr), 32'd1);

    measure1(1'b0, 1'b1, 32'd1044, 32'hA5A5A5A5, 32'h11112222, low, en_n, we_n, guard);
    chk("w1 write timeout", 32'(guard < 20), 32'd1);
    chk("w1 write ready_low_cycles", 32'(low), 32'd2);
    chk("w1 write we_low_cycles", 32'(we_n), 32'd1);
    chk("w1 write readData_kept", if1.readData, 32'h600DCAFE);
    chk("w1 write sram_addr", 32'(if1.sram_addr), 32'd5);
    chk("w1 write sram_wdata", if1.sram_wdata, 32'hA5A5A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
